lifo_fifo_buffer: RTL and testbench
===================================

// Module: lifo_fifo_buffer
// PURPOSE
//  Parametrised storage buffer with a run-time selectable order: LIFO (stack) or FIFO (queue).
//  Generalises the 32x32 stack to any width and depth, and adds occupancy count,
//  almost_full/almost_empty thresholds, and overflow/underflow pulses.
//  Sits between a producer and a consumer in the datapath as a single-clock elastic store.
// PARAMETERS
//  DATA_WIDTH      32  word width in bits
//  DEPTH           32  number of entries; power of two, >= 2
//  ALMOST_FULL_TH  28  almost_full=1 when count >= this value; 1..DEPTH
//  ALMOST_EMPTY_TH  4  almost_empty=1 when count <= this value; 0..DEPTH-1
//  Local: CW = $clog2(DEPTH+1), the count width.
// PORTS
//  clk           in   1           rising-edge clock
//  rst           in   1           synchronous active-high reset
//  mode          in   1           requested order: 0=FIFO, 1=LIFO
//  w_en          in   1           write (push) request
//  r_en          in   1           read (pop) request
//  data_in       in   DATA_WIDTH  write data
//  data_out      out  DATA_WIDTH  registered read data
//  full          out  1           count == DEPTH
//  empty         out  1           count == 0
//  almost_full   out  1           count >= ALMOST_FULL_TH
//  almost_empty  out  1           count <= ALMOST_EMPTY_TH
//  count         out  CW          current occupancy
//  mode_active   out  1           order currently in force
//  overflow      out  1           1-cycle pulse: write requested but rejected
//  underflow     out  1           1-cycle pulse: read requested but rejected
// BEHAVIOUR
//  - Reset: count=0, wr_ptr=0, rd_ptr=0, data_out=0, overflow=0, underflow=0, mode_active<=mode.
//    Flags follow from count: empty=1, full=0, almost_empty=1, almost_full=0.
//    Memory contents are not cleared. Reset mid-operation discards all stored entries.
//  - All flags and count are registered/derived from registered count, so they are valid
//    the cycle after the accepting edge.
//  - mode_active <= mode only on edges where empty==1. Mode changes while non-empty are ignored.
//  - Accepted read: data_out <= selected entry at that edge (1-cycle latency).
//    data_out holds its value on any cycle without an accepted read.
//  - FIFO (mode_active=0): write to mem[wr_ptr] and wr_ptr++; read from mem[rd_ptr] and rd_ptr++.
//    Pointers wrap modulo DEPTH.
//     * w&r, 0<count<DEPTH: both accepted; count unchanged.
//     * w&r, full: both accepted; the read returns the old head; count stays DEPTH.
//     * w&r, empty: write accepted; read rejected (underflow pulse).
//  - LIFO (mode_active=1): push writes mem[wr_ptr] and wr_ptr++.
//    Pop reads mem[wr_ptr-1] (mod DEPTH) and wr_ptr--. rd_ptr is unused.
//     * w&r: push has priority; the read is dropped silently (no underflow pulse).
//       If full, nothing is accepted and overflow pulses.
//  - Write while full (except the FIFO w&r case): ignored, state unchanged, overflow=1 for one cycle.
//  - Read while empty: ignored, data_out unchanged, underflow=1 for one cycle.
//  - count arithmetic: +1 on write only, -1 on read only, 0 on both; never leaves 0..DEPTH.
// CONFIGURATION
//  LIFO_FIFO_PEEK_EN defined: adds output peek [DATA_WIDTH], combinational.
//    It shows the entry the next read would return (FIFO head / LIFO top), or 0 when empty.
//    No side effects on pointers.
//  LIFO_FIFO_PEEK_EN undefined: the peek port and its logic are absent; all other behaviour is identical.
// TESTING  (test data D[i] = 32'hB0000000+i; defaults DATA_WIDTH=32, DEPTH=32)
//  1. rst with mode=1; push D0..D4; pop x5 -> data_out D4,D3,D2,D1,D0; empty=1, count=0 after the last pop.
//  2. rst with mode=0; push D0..D4; pop x5 -> data_out D0..D4 in order; underflow stays 0.
//  3. LIFO: push D0..D31 -> almost_full rises at count=28, full=1 at count=32.
//     Push FFFFFFFF -> overflow pulse, count=32. Pop -> D31.
//  4. FIFO full (D0..D31): w_en=r_en=1 with data_in=FFFFFFFF -> data_out=D0, count=32.
//     Then 32 pops end with FFFFFFFF (exercises wrap-around).
//  5. Empty: pop -> underflow pulse, data_out unchanged. LIFO with 3 entries, w&r with D10 -> count=4, next pop=D10.
//  6. mode flips to 0 with 2 entries in LIFO -> mode_active stays 1.
//     rst mid-fill -> count=0, empty=1, data_out=0 the next cycle.

Source files
------------

// File: rtl/lifo_fifo_buffer.sv
// Single-clock elastic store with run-time selectable LIFO (stack) or FIFO (queue) order.
// Latency: read data registered, 1 cycle after the accepting edge; flags/count valid the cycle after.
// Backpressure: none stalls; rejected writes pulse overflow, rejected reads pulse underflow.
//
// Ports: clk/rst (sync, active-high); mode (0=FIFO,1=LIFO, latched only while empty) -> mode_active;
//        w_en/data_in push side; r_en/data_out pop side; full/empty/almost_full/almost_empty/count
//        status; overflow/underflow one-cycle reject pulses.
// Optional: define LIFO_FIFO_PEEK_EN to add a combinational peek output (next read value, 0 when empty).
module lifo_fifo_buffer #(
    parameter int DATA_WIDTH      = 32,
    parameter int DEPTH           = 32,
    parameter int ALMOST_FULL_TH  = 28,
    parameter int ALMOST_EMPTY_TH = 4,
    localparam int CW             = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic                  w_en,
    input  logic                  r_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
`ifdef LIFO_FIFO_PEEK_EN
    output logic [DATA_WIDTH-1:0] peek,
`endif
    output logic                  mode_active,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW-1:0]         wr_ptr_nxt, rd_ptr_nxt;
    logic [PW-1:0]         wr_ptr_m1, rd_sel;
    logic                  wr_acc, rd_acc, ovf, unf;

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(ALMOST_FULL_TH));
    assign almost_empty = (count <= CW'(ALMOST_EMPTY_TH));

    // LIFO top sits one below the write pointer; FIFO head is the read pointer.
    assign wr_ptr_m1 = wr_ptr - PTR_ONE;
    assign rd_sel    = mode_active ? wr_ptr_m1 : rd_ptr;

`ifdef LIFO_FIFO_PEEK_EN
    assign peek = empty ? '0 : mem[rd_sel];
`endif

    always_comb begin
        wr_acc     = 1'b0;
        rd_acc     = 1'b0;
        ovf        = 1'b0;
        unf        = 1'b0;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (!mode_active) begin
            // FIFO: a simultaneous read frees the slot, so a full write is accepted alongside it.
            wr_acc = w_en && (!full || r_en);
            rd_acc = r_en && !empty;
            ovf    = w_en && full && !r_en;
            unf    = r_en && empty;
            if (wr_acc) wr_ptr_nxt = wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr_nxt = rd_ptr + PTR_ONE;
        end else begin
            // LIFO: push wins over pop; the losing pop is dropped without an underflow pulse.
            if (w_en) begin
                wr_acc = !full;
                ovf    = full;
            end else if (r_en) begin
                rd_acc = !empty;
                unf    = empty;
            end
            if (wr_acc)      wr_ptr_nxt = wr_ptr + PTR_ONE;
            else if (rd_acc) wr_ptr_nxt = wr_ptr_m1;
            // Keep rd_ptr shadowing wr_ptr so a later switch to FIFO starts with equal pointers.
            rd_ptr_nxt = wr_ptr_nxt;
        end
    end

    // Storage is not reset; writes are simply suppressed while rst is high.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            data_out    <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            mode_active <= mode;
        end else begin
            overflow  <= ovf;
            underflow <= unf;
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            if (rd_acc) data_out    <= mem[rd_sel];
            if (empty)  mode_active <= mode;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_lifo_fifo_buffer.sv
// Bench for lifo_fifo_buffer: vector table of per-cycle inputs and expected outputs,
// expectations queued when a vector is driven and compared after the clock edge.
module tb_lifo_fifo_buffer;

    localparam int DW = 32;
    localparam int DEPTH = 32;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst, mode, w_en, r_en;
    logic [DW-1:0] data_in, data_out;
    logic          full, empty, almost_full, almost_empty, mode_active, overflow, underflow;
    logic [CW-1:0] count;
`ifdef LIFO_FIFO_PEEK_EN
    logic [DW-1:0] peek;
`endif

    always #5 clk = ~clk;

    lifo_fifo_buffer #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ALMOST_FULL_TH(28), .ALMOST_EMPTY_TH(4)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .w_en(w_en), .r_en(r_en),
        .data_in(data_in), .data_out(data_out),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count),
`ifdef LIFO_FIFO_PEEK_EN
        .peek(peek),
`endif
        .mode_active(mode_active), .overflow(overflow), .underflow(underflow)
    );

    typedef struct {
        logic          rst, mode, w, r;
        logic [DW-1:0] din;
        logic [DW-1:0] e_dout;
        int            e_cnt;
        logic          e_ovf, e_unf, e_mact;
        string         name;
    } vec_t;

    // {data_out, count, full, empty, almost_full, almost_empty, overflow, underflow, mode_active}
    typedef logic [DW+CW+7-1:0] obs_t;

    vec_t vt[$];
    obs_t sb[$];
    string nm[$];
    int n_vec = 0;
    int n_bad = 0;

    function automatic logic [DW-1:0] d(input int i);
        return 32'hB000_0000 + DW'(i);
    endfunction

    task automatic add(input logic rs, md, w, r, input logic [DW-1:0] din,
                       input logic [DW-1:0] edout, input int ecnt,
                       input logic eovf, eunf, emact, input string name);
        vec_t v;
        v.rst = rs; v.mode = md; v.w = w; v.r = r; v.din = din;
        v.e_dout = edout; v.e_cnt = ecnt; v.e_ovf = eovf; v.e_unf = eunf; v.e_mact = emact;
        v.name = name;
        vt.push_back(v);
    endtask

    function automatic obs_t expect_of(input vec_t v);
        logic [CW-1:0] c;
        c = CW'(v.e_cnt);
        return {v.e_dout, c, (v.e_cnt == DEPTH), (v.e_cnt == 0), (v.e_cnt >= 28),
                (v.e_cnt <= 4), v.e_ovf, v.e_unf, v.e_mact};
    endfunction

    initial begin
        obs_t  exp_o, act_o;
        string cur;
        logic [DW-1:0] FF;
        FF = 32'hFFFF_FFFF;

        // 1: LIFO order
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, "t1_rst");
        for (int i = 0; i < 5; i++) add(0, 1, 1, 0, d(i), 0, i + 1, 0, 0, 1, "t1_push");
        for (int i = 0; i < 5; i++) add(0, 1, 0, 1, 0, d(4 - i), 4 - i, 0, 0, 1, "t1_pop");
        // 2: FIFO order
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "t2_rst");
        for (int i = 0; i < 5; i++) add(0, 0, 1, 0, d(i), 0, i + 1, 0, 0, 0, "t2_push");
        for (int i = 0; i < 5; i++) add(0, 0, 0, 1, 0, d(i), 4 - i, 0, 0, 0, "t2_pop");
        // 3: LIFO fill, thresholds, overflow
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, "t3_rst");
        for (int i = 0; i < 32; i++) add(0, 1, 1, 0, d(i), 0, i + 1, 0, 0, 1, "t3_fill");
        add(0, 1, 1, 0, FF, 0, 32, 1, 0, 1, "t3_ovf");
        add(0, 1, 0, 0, 0, 0, 32, 0, 0, 1, "t3_ovf_clear");
        add(0, 1, 0, 1, 0, d(31), 31, 0, 0, 1, "t3_pop");
        // 4: FIFO full, simultaneous w&r, wrap-around drain
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "t4_rst");
        for (int i = 0; i < 32; i++) add(0, 0, 1, 0, d(i), 0, i + 1, 0, 0, 0, "t4_fill");
        add(0, 0, 1, 0, 32'hDEAD_BEEF, 0, 32, 1, 0, 0, "t4_ovf");
        add(0, 0, 1, 1, FF, d(0), 32, 0, 0, 0, "t4_wr_full");
        for (int i = 0; i < 32; i++)
            add(0, 0, 0, 1, 0, (i == 31) ? FF : d(i + 1), 31 - i, 0, 0, 0, "t4_drain");
        // 5: underflow, FIFO w&r on empty, LIFO w&r priority
        add(0, 0, 0, 1, 0, FF, 0, 0, 1, 0, "t5_unf");
        add(0, 0, 1, 1, d(20), FF, 1, 0, 1, 0, "t5_wr_empty");
        add(0, 0, 0, 1, 0, d(20), 0, 0, 0, 0, "t5_pop");
        add(0, 1, 0, 0, 0, d(20), 0, 0, 0, 1, "t5_to_lifo");
        for (int i = 0; i < 3; i++) add(0, 1, 1, 0, d(i), d(20), i + 1, 0, 0, 1, "t5_push");
        add(0, 1, 1, 1, d(10), d(20), 4, 0, 0, 1, "t5_lifo_wr");
        add(0, 1, 0, 1, 0, d(10), 3, 0, 0, 1, "t5_pop_top");
        add(0, 1, 0, 1, 0, d(2), 2, 0, 0, 1, "t6_pop");
        // 6: mode change ignored while non-empty; reset mid-fill
        add(0, 0, 0, 0, 0, d(2), 2, 0, 0, 1, "t6_mode_hold");
        add(0, 0, 1, 0, d(30), d(2), 3, 0, 0, 1, "t6_push_lifo");
        add(0, 0, 0, 1, 0, d(30), 2, 0, 0, 1, "t6_pop_lifo");
        add(1, 0, 1, 0, d(7), 0, 0, 0, 0, 0, "t6_rst_mid");
        add(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, "t6_unf_after_rst");

        for (int i = 0; i < vt.size(); i++) begin
            rst = vt[i].rst; mode = vt[i].mode; w_en = vt[i].w; r_en = vt[i].r;
            data_in = vt[i].din;
            sb.push_back(expect_of(vt[i]));
            nm.push_back(vt[i].name);
            @(posedge clk);
            #1;
            act_o = {data_out, count, full, empty, almost_full, almost_empty,
                     overflow, underflow, mode_active};
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_empty vec=%0d actual=%h", i, act_o);
            end else begin
                exp_o = sb.pop_front();
                cur = nm.pop_front();
                if (act_o !== exp_o) begin
                    n_bad++;
                    $display("FAIL %s vec=%0d actual dout=%h cnt=%0d flags(f,e,af,ae,ov,un,m)=%b required dout=%h cnt=%0d flags=%b",
                             cur, i, act_o[DW+CW+6:CW+7], act_o[CW+6:7], act_o[6:0],
                             exp_o[DW+CW+6:CW+7], exp_o[CW+6:7], exp_o[6:0]);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
